// File: rtl/rand_pkg.sv
// Shared constants and helpers for the mask randomness buffer.
package rand_pkg;

  localparam int unsigned RNG_W = 32;
  localparam int unsigned CNT_W = 16;

  function automatic int unsigned slices_per_word(input int unsigned out_w);
    return RNG_W / out_w;
  endfunction

endpackage

// File: rtl/rand_word_fifo.sv
// Synchronous word FIFO with flush; head is the word at the read pointer.
module rand_word_fifo
  import rand_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [RNG_W-1:0]         wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [RNG_W-1:0]         head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [RNG_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;

  // When full, push is only allowed alongside a pop, so the slot written is the one freed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rand_mask_buffer.sv
// Buffers PRNG words and dispenses each bit once as OUT_W-bit mask slices.
module rand_mask_buffer
  import rand_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned WARMUP = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [RNG_W-1:0]         rng_in,
  input  logic                     rng_vld,
  input  logic                     flush,
  input  logic                     mask_ready,
  output logic                     mask_valid,
  output logic [OUT_W-1:0]         mask_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         underrun_cnt
);

  localparam int unsigned SPW   = slices_per_word(OUT_W);
  localparam int unsigned SEL_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int unsigned WU_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [SEL_W-1:0]            sel_q;
  logic [WU_W-1:0]             wu_cnt_q;
  logic [CNT_W-1:0]            underrun_q;
  logic [LVL_W-1:0]            count;
  logic [RNG_W-1:0]            head;
  logic [SPW-1:0][OUT_W-1:0]   slices;
  logic                        warm_done, last_slice, fire, push, pop;

  assign warm_done  = (wu_cnt_q == WU_W'(WARMUP));
  assign last_slice = (sel_q == SEL_W'(SPW - 1));
  assign mask_valid = (count != '0);
  assign fire       = mask_valid & mask_ready;
  assign pop        = fire & last_slice & ~flush;
  assign push       = warm_done & rng_vld & ~flush & ((count < LVL_W'(DEPTH)) | pop);

  rand_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (rng_in),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q      <= '0;
      wu_cnt_q   <= '0;
      underrun_q <= '0;
    end else begin
      if (rng_vld && !warm_done) wu_cnt_q <= wu_cnt_q + 1'b1;
      if (mask_ready && !mask_valid && underrun_q != '1) underrun_q <= underrun_q + 1'b1;
      if (flush)      sel_q <= '0;
      else if (fire)  sel_q <= last_slice ? '0 : sel_q + 1'b1;
    end
  end

  // Gate the slice so stale randomness never appears on the bus while invalid.
  assign slices       = head;
  assign mask_out     = mask_valid ? slices[sel_q] : '0;
  assign level        = count;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_rand_mask_buffer.sv
// Directed bench for rand_mask_buffer with DEPTH=4, OUT_W=8, WARMUP=2.
module tb_rand_mask_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rng_in = '0;
  logic        rng_vld = 1'b0;
  logic        flush = 1'b0;
  logic        mask_ready = 1'b0;
  logic        mask_valid;
  logic [7:0]  mask_out;
  logic [2:0]  level;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int failures = 0;

  rand_mask_buffer #(
    .DEPTH  (4),
    .OUT_W  (8),
    .WARMUP (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rng_in       (rng_in),
    .rng_vld      (rng_vld),
    .flush        (flush),
    .mask_ready   (mask_ready),
    .mask_valid   (mask_valid),
    .mask_out     (mask_out),
    .level        (level),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(mask_valid), 32'd0);
    check({tag, "_out"},   32'(mask_out),   32'd0);
    check({tag, "_level"}, 32'(level),      32'd0);
  endtask

  logic [31:0] words [4];

  initial begin
    // Reset
    step();
    step();
    check_idle("reset");
    check("reset_underrun", 32'(underrun_cnt), 32'd0);
    rst_n = 1'b1;

    // Warm-up: first two words discarded
    rng_vld = 1'b1;
    rng_in  = 32'h0000_0000;
    step();
    check_idle("warm0");
    rng_in = 32'h1111_1111;
    step();
    check_idle("warm1");
    rng_in = 32'hA1B2_C3D4;
    step();
    check("warm2_valid", 32'(mask_valid), 32'd1);
    check("warm2_level", 32'(level), 32'd1);
    rng_vld = 1'b0;

    // Slicing, LSB first
    mask_ready = 1'b1;
    check("slice0", 32'(mask_out), 32'hD4);
    step();
    check("slice1", 32'(mask_out), 32'hC3);
    step();
    check("slice2", 32'(mask_out), 32'hB2);
    step();
    check("slice3", 32'(mask_out), 32'hA1);
    step();
    mask_ready = 1'b0;
    check_idle("drained");
    check("no_underrun_a", 32'(underrun_cnt), 32'd0);

    // Full / drop: six pushes into depth 4
    rng_vld = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      rng_in = 32'(i);
      step();
    end
    rng_vld = 1'b0;
    check("full_level", 32'(level), 32'd4);
    check("full_head", 32'(mask_out), 32'h01);

    // Consume slices 0..2 of word 1, then pop last slice with a push while full
    mask_ready = 1'b1;
    step();
    check("w1_s1", 32'(mask_out), 32'h00);
    step();
    step();
    rng_vld = 1'b1;
    rng_in  = 32'h0000_0077;
    step();
    rng_vld = 1'b0;
    check("pushpop_level", 32'(level), 32'd4);

    words[0] = 32'h2;
    words[1] = 32'h3;
    words[2] = 32'h4;
    words[3] = 32'h77;
    for (int w = 0; w < 4; w++) begin
      check($sformatf("order_level%0d", w), 32'(level), 32'(4 - w));
      for (int s = 0; s < 4; s++) begin
        check($sformatf("order_w%0d_s%0d", w, s), 32'(mask_out), (words[w] >> (8 * s)) & 32'hFF);
        step();
      end
    end
    mask_ready = 1'b0;
    check_idle("order_done");
    check("no_underrun_b", 32'(underrun_cnt), 32'd0);

    // Flush with level=3, sel=2, plus a concurrent push and fire
    rng_vld = 1'b1;
    rng_in = 32'hA0A1_A2A3; step();
    rng_in = 32'hB0B1_B2B3; step();
    rng_in = 32'hC0C1_C2C3; step();
    rng_vld = 1'b0;
    check("preflush_level", 32'(level), 32'd3);
    mask_ready = 1'b1;
    step();
    step();
    check("preflush_out", 32'(mask_out), 32'hA1);
    flush   = 1'b1;
    rng_vld = 1'b1;
    rng_in  = 32'hDEAD_BEEF;
    step();
    flush      = 1'b0;
    rng_vld    = 1'b0;
    mask_ready = 1'b0;
    check_idle("flush");
    step();
    check_idle("flush_hold");
    check("no_underrun_c", 32'(underrun_cnt), 32'd0);

    // Underrun saturation
    mask_ready = 1'b1;
    step();
    check("underrun_one", 32'(underrun_cnt), 32'd1);
    repeat (70000) @(posedge clk);
    #1;
    check("underrun_sat", 32'(underrun_cnt), 32'hFFFF);

    // Reset mid-stream re-arms warm-up
    rst_n = 1'b0;
    mask_ready = 1'b0;
    rng_vld = 1'b1;
    rng_in  = 32'h5555_5555;
    step();
    check_idle("rst2");
    check("rst2_underrun", 32'(underrun_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    check_idle("rewarm0");
    rng_in = 32'h6666_6666;
    step();
    check_idle("rewarm1");
    rng_in = 32'h7777_77F7;
    step();
    rng_vld = 1'b0;
    check("rewarm2_valid", 32'(mask_valid), 32'd1);
    check("rewarm2_out", 32'(mask_out), 32'hF7);
    check("rewarm2_level", 32'(level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_mask_buffer.md
Name: rand_mask_buffer

Overview:
Consumer stage directly downstream of the 32-bit free-running xorshift PRNG in the masked (LMDPL) AES datapath. Buffers PRNG words in a small FIFO and dispenses them as OUT_W-bit fresh mask slices to masked gadgets over a valid/ready handshake. Guarantees each random bit is delivered at most once. Discards the PRNG's post-reset warm-up words. Drops words when full, since the PRNG has no backpressure.

Parameters:
DEPTH, 4, FIFO depth in 32-bit words; power of 2, >= 2
OUT_W, 8, mask slice width; must divide 32 (1, 2, 4, 8, 16, 32)
WARMUP, 2, PRNG words ignored after reset

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
rng_in  in  32  PRNG output word
rng_vld  in  1  rng_in carries a new word this cycle (tie 1 for free-running PRNG)
flush  in  1  synchronous discard of all buffered randomness
mask_ready  in  1  consumer accepts mask_out this cycle
mask_valid  out  1  mask_out holds an unused slice
mask_out  out  OUT_W  current mask slice
level  out  $clog2(DEPTH)+1  words held, including a partially consumed head word
underrun_cnt  out  16  saturating count of cycles with mask_ready=1 and mask_valid=0

Behaviour:
- Reset (rst_n=0 at posedge): count, wr/rd pointers, slice index sel, warm-up counter and underrun_cnt = 0; storage cleared to 0.
- Reset outputs: mask_valid=0, mask_out=0, level=0, underrun_cnt=0.
- Warm-up: after reset, the first WARMUP cycles with rng_vld=1 are discarded (this covers the PRNG's 0x0 first output). Counter saturates; only reset re-arms it.
- Push: when warm-up is done and rng_vld=1, the word is written if count<DEPTH, or if a head-word pop occurs in the same cycle. Otherwise the word is dropped silently.
- Output: mask_valid = (count!=0). mask_out = head[sel*OUT_W +: OUT_W], LSB slice first.
- Leakage rule: mask_out must be forced to 0 whenever mask_valid=0. No combinational path from rng_in to mask_out.
- Write-to-valid latency: 1 cycle; a word pushed at edge N is visible after edge N.
- Fire = mask_valid & mask_ready. On fire, sel increments.
- Head pop: when sel = 32/OUT_W-1 at fire, sel wraps to 0, the head is popped, and rd_ptr advances.
- Simultaneous push+pop: count unchanged, including when full.
- Pointers wrap modulo DEPTH. count range is 0..DEPTH.
- level = count.
- underrun_cnt increments on mask_ready & ~mask_valid and saturates at 0xFFFF.
- flush: highest priority below reset. count, pointers and sel go to 0; any push and fire that cycle are ignored. Warm-up and underrun_cnt are unaffected. mask_valid=0 on the following cycle.
- Reset mid-operation: all state cleared as above; warm-up restarts.

Decomposition:
- Package rand_pkg: RNG_W=32, function slices_per_word(OUT_W)=32/OUT_W, CNT_W=16.
- One sub-module, rand_word_fifo: synchronous DEPTH x 32 FIFO with push, pop, flush, count and head output.
- Slice selection, warm-up, gating and the underrun counter live in the top level.

Test Plan:
- Warm-up: reset, then drive rng_vld=1 with words 0x00000000, 0x11111111, 0xA1B2C3D4. Required: first two dropped; after the third edge mask_valid=1, level=1.
- Slicing: continue from the previous test with mask_ready=1. Required: mask_out = 0xD4, 0xC3, 0xB2, 0xA1 on consecutive cycles, then mask_valid=0 and mask_out=0x00.
- Full/drop: with mask_ready=0, push 6 words 0x1..0x6, DEPTH=4. Required: level=4. Words 0x5 and 0x6 dropped; the dispensed order starts 0x01 slice of word 0x1.
- Full with simultaneous push and last-slice pop: required level stays 4, and the new word appears as the tail (5th word dispensed).
- Flush: with level=3 and sel=2, assert flush together with rng_vld=1. Required: next cycle level=0, mask_valid=0, mask_out=0, and the pushed word is absent.
- Underrun: hold mask_ready=1 for 70000 cycles with rng_vld=0. Required: underrun_cnt=0xFFFF. Apply reset mid-stream: all outputs 0 and warm-up discards the next 2 words.
